// File: rtl/vx_barrier_unit_pkg.sv
// Shared GPU definitions used by the barrier unit: sizing macros, the barrier request type, and derived widths.
`ifndef NUM_WARPS
`define NUM_WARPS 8
`endif
`ifndef NUM_BARRIERS
`define NUM_BARRIERS 4
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 3
`endif
`ifndef NB_WIDTH
`define NB_WIDTH 2
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 32
`endif

package vx_barrier_unit_pkg;

    typedef struct packed {
        logic                 valid;
        logic [`NB_WIDTH-1:0] id;
        logic [`NW_WIDTH-1:0] size_m1;
        logic                 is_global;
        logic                 is_noop;
    } barrier_t;

    localparam int WARPS    = `NUM_WARPS;
    localparam int BARRIERS = `NUM_BARRIERS;
    localparam int NW_W     = `NW_WIDTH;
    localparam int NB_W     = `NB_WIDTH;
    localparam int PERF_W   = `PERF_CTR_BITS;

endpackage

// File: rtl/vx_bar_slot.sv
// One barrier slot: arrival count, waiting mask, and the completion / duplicate decision for one arrival.
module vx_bar_slot #(
    parameter int NUM_WARPS = `NUM_WARPS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 arrive,
    input  logic [`NW_WIDTH-1:0] wid,
    input  logic [`NW_WIDTH-1:0] size_m1,
    output logic                 done,
    output logic                 dup,
    output logic [NUM_WARPS-1:0] mask_next,
    output logic [NUM_WARPS-1:0] rel_mask
);

    logic [`NW_WIDTH-1:0] count;
    logic [`NW_WIDTH-1:0] count_next;
    logic [NUM_WARPS-1:0] mask;
    logic [NUM_WARPS-1:0] wid_onehot;

    // A repeat arrival takes priority over completion so it never releases the barrier.
    always_comb begin
        wid_onehot      = '0;
        wid_onehot[wid] = 1'b1;
        dup             = arrive && mask[wid];
        done            = arrive && !mask[wid] && (count == size_m1);
        rel_mask        = mask | wid_onehot;
        count_next      = count;
        mask_next       = mask;
        if (done) begin
            count_next = '0;
            mask_next  = '0;
        end else if (arrive && !dup) begin
            count_next = count + `NW_WIDTH'(1);
            mask_next  = rel_mask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            mask  <= '0;
        end else begin
            count <= count_next;
            mask  <= mask_next;
        end
    end

endmodule

// File: rtl/vx_barrier_unit.sv
// Local warp barrier unit: parks arriving warps per barrier slot and pulses a release when the last one arrives.
// Optional BAR_PERF_EN adds perf_stall_cycles, accumulating parked-warp cycles.
module vx_barrier_unit
    import vx_barrier_unit_pkg::*;
#(
    parameter int NUM_WARPS    = `NUM_WARPS,
    parameter int NUM_BARRIERS = `NUM_BARRIERS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     bar_valid,
    input  logic [`NW_WIDTH-1:0]     bar_wid,
    input  barrier_t                 bar_req,
    output logic                     release_valid,
    output logic [NUM_WARPS-1:0]     release_mask,
    output logic [NUM_WARPS-1:0]     stall_mask,
    output logic                     dup_err
`ifdef BAR_PERF_EN
    ,
    output logic [`PERF_CTR_BITS-1:0] perf_stall_cycles
`endif
);

    logic                    req_ok;
    logic [NUM_BARRIERS-1:0] slot_arrive;
    logic [NUM_BARRIERS-1:0] slot_done;
    logic [NUM_BARRIERS-1:0] slot_dup;
    logic [NUM_WARPS-1:0]    slot_mask_next [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    slot_rel_mask  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    rel_next;
    logic [NUM_WARPS-1:0]    stall_next;
    logic                    unused_req_valid;

    assign unused_req_valid = bar_req.valid;
    assign req_ok = bar_valid && !bar_req.is_noop && !bar_req.is_global;

    always_comb begin
        slot_arrive = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            slot_arrive[b] = req_ok && (bar_req.id == `NB_WIDTH'(b));
        end
    end

    for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_slot
        vx_bar_slot #(.NUM_WARPS(NUM_WARPS)) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .arrive    (slot_arrive[g]),
            .wid       (bar_wid),
            .size_m1   (bar_req.size_m1),
            .done      (slot_done[g]),
            .dup       (slot_dup[g]),
            .mask_next (slot_mask_next[g]),
            .rel_mask  (slot_rel_mask[g])
        );
    end

    // stall_mask is built from next-state masks so a release and the stall drop land together.
    always_comb begin
        rel_next   = '0;
        stall_next = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (slot_done[b]) begin
                rel_next = rel_next | slot_rel_mask[b];
            end
            stall_next = stall_next | slot_mask_next[b];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            release_valid <= 1'b0;
            release_mask  <= '0;
            stall_mask    <= '0;
            dup_err       <= 1'b0;
        end else begin
            release_valid <= |slot_done;
            release_mask  <= rel_next;
            stall_mask    <= stall_next;
            dup_err       <= |slot_dup;
        end
    end

`ifdef BAR_PERF_EN
    logic [`PERF_CTR_BITS-1:0] stall_pop;

    always_comb begin
        stall_pop = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            stall_pop = stall_pop + `PERF_CTR_BITS'(stall_mask[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cycles <= '0;
        end else begin
            perf_stall_cycles <= perf_stall_cycles + stall_pop;
        end
    end
`endif

endmodule

// File: tb/tb_vx_barrier_unit.sv
// Directed self-checking bench for vx_barrier_unit; inputs change and outputs are sampled on the falling edge.
module tb_vx_barrier_unit;
    import vx_barrier_unit_pkg::*;

    logic             clk;
    logic             reset_n;
    logic             bar_valid;
    logic [NW_W-1:0]  bar_wid;
    barrier_t         bar_req;
    logic             release_valid;
    logic [WARPS-1:0] release_mask;
    logic [WARPS-1:0] stall_mask;
    logic             dup_err;
`ifdef BAR_PERF_EN
    logic [PERF_W-1:0] perf_stall_cycles;
    logic [PERF_W-1:0] perf_start;
`endif

    int checks = 0;
    int errors = 0;

    vx_barrier_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bar_valid     (bar_valid),
        .bar_wid       (bar_wid),
        .bar_req       (bar_req),
        .release_valid (release_valid),
        .release_mask  (release_mask),
        .stall_mask    (stall_mask),
        .dup_err       (dup_err)
`ifdef BAR_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one request at a falling edge and return at the next falling edge, after the DUT has consumed it.
    task automatic applyStimulus(input logic v, input int wid, input int id, input int sz,
                                 input logic noop = 1'b0, input logic glob = 1'b0);
        bar_valid         = v;
        bar_wid           = NW_W'(wid);
        bar_req.valid     = v;
        bar_req.id        = NB_W'(id);
        bar_req.size_m1   = NW_W'(sz);
        bar_req.is_noop   = noop;
        bar_req.is_global = glob;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 0, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        bar_valid = 1'b0;
        bar_wid = '0;
        bar_req = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_release_valid", 32'(release_valid), 32'h0);
        checkOutput("reset_release_mask", 32'(release_mask), 32'h0);
        checkOutput("reset_stall_mask", 32'(stall_mask), 32'h0);
        checkOutput("reset_dup_err", 32'(dup_err), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] four warps on barrier 1, size_m1=3");
        applyStimulus(1'b1, 0, 1, 3);
        checkOutput("b4_stall_a0", 32'(stall_mask), 32'h01);
        checkOutput("b4_no_rel_a0", 32'(release_valid), 32'h0);
        applyStimulus(1'b1, 1, 1, 3);
        checkOutput("b4_stall_a1", 32'(stall_mask), 32'h03);
        applyStimulus(1'b1, 2, 1, 3);
        checkOutput("b4_stall_a2", 32'(stall_mask), 32'h07);
        checkOutput("b4_no_rel_a2", 32'(release_valid), 32'h0);
        applyStimulus(1'b1, 3, 1, 3);
        checkOutput("b4_release_valid", 32'(release_valid), 32'h1);
        checkOutput("b4_release_mask", 32'(release_mask), 32'h0F);
        checkOutput("b4_stall_cleared", 32'(stall_mask), 32'h00);
        idleCycle();
        checkOutput("b4_pulse_one_cycle", 32'(release_valid), 32'h0);

        $display("[TB] warp 5 alone with size_m1=0");
        applyStimulus(1'b1, 5, 2, 0);
        checkOutput("solo_release_valid", 32'(release_valid), 32'h1);
        checkOutput("solo_release_mask", 32'(release_mask), 32'h20);
        checkOutput("solo_stall", 32'(stall_mask), 32'h00);
        idleCycle();
        checkOutput("solo_stall_after", 32'(stall_mask), 32'h00);

        $display("[TB] duplicate arrival of warp 2 on barrier 0");
        applyStimulus(1'b1, 2, 0, 2);
        checkOutput("dup_first_stall", 32'(stall_mask), 32'h04);
        checkOutput("dup_first_no_err", 32'(dup_err), 32'h0);
        applyStimulus(1'b1, 2, 0, 2);
        checkOutput("dup_err_pulse", 32'(dup_err), 32'h1);
        checkOutput("dup_stall_kept", 32'(stall_mask), 32'h04);
        checkOutput("dup_no_release", 32'(release_valid), 32'h0);
        idleCycle();
        checkOutput("dup_err_one_cycle", 32'(dup_err), 32'h0);
        applyStimulus(1'b1, 3, 0, 2);
        checkOutput("dup_count_second", 32'(release_valid), 32'h0);
        checkOutput("dup_stall_second", 32'(stall_mask), 32'h0C);
        applyStimulus(1'b1, 4, 0, 2);
        checkOutput("dup_count_third_rel", 32'(release_valid), 32'h1);
        checkOutput("dup_rel_mask", 32'(release_mask), 32'h1C);

        $display("[TB] interleaved pairs on barriers 0 and 1");
        applyStimulus(1'b1, 0, 0, 1);
        checkOutput("pair_stall_a", 32'(stall_mask), 32'h01);
        applyStimulus(1'b1, 2, 1, 1);
        checkOutput("pair_stall_b", 32'(stall_mask), 32'h05);
        applyStimulus(1'b1, 1, 0, 1);
        checkOutput("pair0_release_valid", 32'(release_valid), 32'h1);
        checkOutput("pair0_release_mask", 32'(release_mask), 32'h03);
        checkOutput("pair0_stall", 32'(stall_mask), 32'h04);
        applyStimulus(1'b1, 3, 1, 1);
        checkOutput("pair1_release_valid", 32'(release_valid), 32'h1);
        checkOutput("pair1_release_mask", 32'(release_mask), 32'h0C);
        checkOutput("pair1_stall", 32'(stall_mask), 32'h00);
        idleCycle();

        $display("[TB] noop and global requests are ignored");
        applyStimulus(1'b1, 6, 3, 1);
        checkOutput("ign_park", 32'(stall_mask), 32'h40);
        applyStimulus(1'b1, 7, 3, 1, 1'b1, 1'b0);
        checkOutput("noop_stall", 32'(stall_mask), 32'h40);
        checkOutput("noop_no_release", 32'(release_valid), 32'h0);
        applyStimulus(1'b1, 7, 3, 1, 1'b0, 1'b1);
        checkOutput("global_stall", 32'(stall_mask), 32'h40);
        checkOutput("global_no_release", 32'(release_valid), 32'h0);
        applyStimulus(1'b1, 6, 3, 1, 1'b1, 1'b0);
        checkOutput("noop_no_dup", 32'(dup_err), 32'h0);
        applyStimulus(1'b1, 7, 3, 1);
        checkOutput("ign_then_release", 32'(release_valid), 32'h1);
        checkOutput("ign_then_mask", 32'(release_mask), 32'hC0);
        idleCycle();

        $display("[TB] reset in the middle of accumulation");
        applyStimulus(1'b1, 0, 1, 3);
        applyStimulus(1'b1, 1, 1, 3);
        checkOutput("mid_stall_pre", 32'(stall_mask), 32'h03);
        bar_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_async_clear", 32'(stall_mask), 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b1, 2, 1, 3);
        applyStimulus(1'b1, 3, 1, 3);
        checkOutput("mid_post_no_rel", 32'(release_valid), 32'h0);
        checkOutput("mid_post_stall", 32'(stall_mask), 32'h0C);
        applyStimulus(1'b1, 4, 1, 3);
        checkOutput("mid_third_no_rel", 32'(release_valid), 32'h0);
        applyStimulus(1'b1, 5, 1, 3);
        checkOutput("mid_fourth_rel", 32'(release_valid), 32'h1);
        checkOutput("mid_fourth_mask", 32'(release_mask), 32'h3C);
        idleCycle();

`ifdef BAR_PERF_EN
        $display("[TB] stall cycle counter with three parked warps");
        applyStimulus(1'b1, 0, 2, 3);
        applyStimulus(1'b1, 1, 2, 3);
        applyStimulus(1'b1, 2, 2, 3);
        bar_valid = 1'b0;
        perf_start = perf_stall_cycles;
        repeat (10) @(negedge clk);
        checkOutput("perf_delta", 32'(perf_stall_cycles - perf_start), 32'd30);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vx_barrier_unit.md
VX_BARRIER_UNIT -- requirements
Module: vx_barrier_unit

Interface
REQ-001 SHALL have parameter NUM_WARPS, default `NUM_WARPS, the number of warps tracked.
REQ-002 SHALL have parameter NUM_BARRIERS, default `NUM_BARRIERS, the number of local barrier slots; the id width is `NB_WIDTH.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port bar_valid, input, 1, a barrier request is present this cycle.
REQ-006 SHALL have port bar_wid, input, `NW_WIDTH, the id of the requesting warp.
REQ-007 SHALL have port bar_req, input, $bits(barrier_t), the barrier request from the shared package (valid field ignored; bar_valid governs).
REQ-008 SHALL have port release_valid, output, 1, a one-cycle release pulse.
REQ-009 SHALL have port release_mask, output, NUM_WARPS, the warps released; valid only with release_valid.
REQ-010 SHALL have port stall_mask, output, NUM_WARPS, the warps currently parked at any barrier.
REQ-011 SHALL have port dup_err, output, 1, a one-cycle pulse on a duplicate arrival.

Function
REQ-012 SHALL accept one request per cycle with no backpressure: no ready signal; a request is consumed whenever bar_valid=1.
REQ-013 SHALL keep per-barrier state: arrival count (`NW_WIDTH bits) and waiting mask (NUM_WARPS bits).
REQ-014 SHALL ignore requests with is_noop=1 or is_global=1: no state change and no outputs.
REQ-015 On an arrival where count==size_m1, SHALL register release_mask = waiting mask | onehot(bar_wid) and pulse release_valid on the next cycle; that barrier's count and mask SHALL clear in the same edge.
REQ-016 Otherwise, an arrival SHALL increment count by 1 and set bit bar_wid in the waiting mask.
REQ-017 size_m1=0 SHALL release the arriving warp alone, one cycle later.
REQ-018 An arrival whose warp is already set in that barrier's mask SHALL leave the state unchanged and pulse dup_err on the next cycle.
REQ-019 stall_mask SHALL be registered as the OR of all waiting masks and SHALL be updated in the same edge as the state, so a released warp drops from stall_mask in the same cycle release_valid asserts.
REQ-020 size_m1 SHALL be taken from the completing arrival; earlier arrivals' size_m1 values are not stored.
REQ-021 Arrivals to different barriers on consecutive cycles SHALL be independent; back-to-back completions SHALL produce back-to-back release pulses.

Reset
REQ-022 On reset_n=0, at any time and including mid-accumulation, all counts and masks SHALL clear, and release_valid=0, release_mask=0, stall_mask=0, dup_err=0; pending arrivals SHALL be discarded.

Configuration
REQ-023 With BAR_PERF_EN defined, the block SHALL add output perf_stall_cycles [`PERF_CTR_BITS], which adds popcount(stall_mask) every cycle, wraps on overflow, and is reset to 0.
REQ-024 Without BAR_PERF_EN, the port and the counter SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-025 barrier_t, `NB_WIDTH and `NW_WIDTH SHALL come from the shared GPU package; no new package types are needed.
REQ-026 A sub-module vx_bar_slot (count, mask, and completion compare for one barrier) SHALL be instantiated NUM_BARRIERS times.

Verification
REQ-027 The bench SHALL cover: warps 0,1,2,3 arrive on barrier 1 with size_m1=3 on consecutive cycles -> release_valid on the cycle after the 4th arrival, release_mask=4'b1111, and stall_mask=0 in that cycle.
REQ-028 The bench SHALL cover: warp 5 arrives with size_m1=0 -> the next cycle gives release_valid=1 and release_mask=onehot(5); stall_mask never sets bit 5.
REQ-029 The bench SHALL cover: warp 2 arrives twice on barrier 0 (size_m1=2) -> dup_err pulses once, count stays 1, and stall_mask bit 2 stays 1.
REQ-030 The bench SHALL cover: warps 0,1 on barrier 0 and warps 2,3 on barrier 1 interleaved, both with size_m1=1 -> two separate pulses with masks 0x3 and 0xC.
REQ-031 The bench SHALL cover: two of four arrivals, then reset_n low for one cycle, then two arrivals -> no release; stall_mask shows only the two post-reset warps.
REQ-032 The bench SHALL cover: bar_valid with is_noop=1 or is_global=1 -> all outputs and state unchanged; with BAR_PERF_EN, 3 warps parked for 10 cycles -> perf_stall_cycles increases by 30.
